// File: rtl/octal_ascii_accumulator.sv
// Assembles a CR/LF-terminated line of ASCII octal digits into a packed binary
// word and presents it, with digit count and error flag, on a valid/ready output.
module octal_ascii_accumulator #(
  parameter  int MAX_DIGITS = 4,
  localparam int W          = 3*MAX_DIGITS,
  localparam int CW         = $clog2(MAX_DIGITS+1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_char_valid,
  input  logic [7:0]    i_char_data,
  output logic          o_char_ready,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [W-1:0]  o_out_binary,
  output logic [CW-1:0] o_out_digits,
  output logic          o_out_error
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISCARD, S_HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_acc, w_acc_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_out_valid;
  logic [W-1:0]  r_out_binary;
  logic [CW-1:0] r_out_digits;
  logic          r_out_error;

  logic w_is_dig, w_is_term, w_char_hs, w_out_hs, w_ld_ok, w_ld_err;

  // '0'..'7' are exactly 0x30..0x37, so the upper five bits identify a digit
  assign w_is_dig  = (i_char_data[7:3] == 5'b00110);
  assign w_is_term = (i_char_data == 8'h0D) || (i_char_data == 8'h0A);
  // ready comes from registered state only, so no path from i_out_ready
  assign o_char_ready = (r_state != S_HOLD);
  assign w_char_hs    = i_char_valid && o_char_ready;
  assign w_out_hs     = r_out_valid && i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ld_ok     = 1'b0;
    w_ld_err    = 1'b0;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_char_hs) begin
          if (w_is_dig) begin
            if (r_cnt == CW'(MAX_DIGITS)) begin
              w_state_nxt = S_DISCARD;
            end else begin
              w_acc_nxt   = {r_acc[W-4:0], i_char_data[2:0]};
              w_cnt_nxt   = r_cnt + CW'(1);
              w_state_nxt = S_ACCUM;
            end
          end else if (w_is_term) begin
            // a terminator with no digits is an empty line and is dropped
            if (r_state == S_ACCUM) begin
              w_ld_ok     = 1'b1;
              w_state_nxt = S_HOLD;
            end
          end else begin
            w_state_nxt = S_DISCARD;
          end
        end
      end
      S_DISCARD: begin
        if (w_char_hs && w_is_term) begin
          w_ld_err    = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_out_hs) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // result registers keep their last value after the handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_binary <= '0;
      r_out_digits <= '0;
      r_out_error  <= 1'b0;
    end else if (w_ld_ok) begin
      r_out_valid  <= 1'b1;
      r_out_binary <= r_acc;
      r_out_digits <= r_cnt;
      r_out_error  <= 1'b0;
    end else if (w_ld_err) begin
      r_out_valid  <= 1'b1;
      r_out_binary <= '0;
      r_out_digits <= '0;
      r_out_error  <= 1'b1;
    end else if (w_out_hs) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_out_binary = r_out_binary;
  assign o_out_digits = r_out_digits;
  assign o_out_error  = r_out_error;

endmodule
